// File: rtl/alu_divider_pkg.sv
// Shared types and default widths for the iterative restoring divider.
package alu_div_pkg;

    // Controller states: waiting, stepping through dividend bits, result held.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIVIDEND_W_DEF = 8;
    localparam int DIVISOR_W_DEF  = 4;
    localparam int CNT_W_DEF      = $clog2(DIVIDEND_W_DEF);

endpackage

// File: rtl/alu_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor if it fits, report the quotient bit.
module div_step #(
    parameter int DIVISOR_W = 4
) (
    input  logic [DIVISOR_W-1:0] rem_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W-1:0] rem_o,
    output logic                 q_o
);

    // The stored remainder is always below the divisor, so it fits in
    // DIVISOR_W bits; only the shifted value needs the extra bit.
    logic [DIVISOR_W:0] shifted;

    // Compare and conditionally subtract at DIVISOR_W+1 bits, unsigned.
    // The true difference is below the divisor, so its low bits are exact.
    always_comb begin
        shifted = {rem_i, bit_i};
        q_o     = (shifted >= {1'b0, divisor_i});
        rem_o   = q_o ? (shifted[DIVISOR_W-1:0] - divisor_i) : shifted[DIVISOR_W-1:0];
    end

endmodule

// File: rtl/alu_divider.sv
// Iterative restoring divider with Start/Busy/Done handshake.
// Handshake: Start is sampled on each rising Clock edge and accepted only in
// IDLE or DONE; operands are captured on that edge. Busy is high in RUN, Done
// is high in DONE while Quotient/Remainder/DivByZero are valid and held until
// the next accepted Start. Start during RUN is ignored.
module alu_divider
    import alu_div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  Clock,
    input  logic                  Reset_b,
    input  logic                  Start,
    input  logic [DIVIDEND_W-1:0] Dividend,
    input  logic [DIVISOR_W-1:0]  Divisor,
    output logic                  Busy,
    output logic                  Done,
    output logic [DIVIDEND_W-1:0] Quotient,
    output logic [DIVISOR_W-1:0]  Remainder,
    output logic                  DivByZero,
    output state_t                State
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [DIVIDEND_W-1:0] dvd_q;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVIDEND_W-1:0] acc_q;
    logic [DIVIDEND_W-1:0] quo_q;
    logic [DIVISOR_W-1:0]  rmd_q;
    logic                  dbz_q;

    logic                  accept;
    logic [DIVISOR_W-1:0]  step_rem;
    logic                  step_q;

    assign accept = Start && (state_q != RUN);

    div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[cnt_q]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // State register; reset drops straight to IDLE without a clock edge.
    always_ff @(posedge Clock or posedge Reset_b) begin
        if (Reset_b) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state: zero divisor skips RUN and lands in DONE on the accepting edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (accept) state_d = (Divisor == '0) ? DONE : RUN;
            RUN:        if (cnt_q == '0) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; Busy and Done are exclusive.
    always_comb begin
        Busy  = (state_q == RUN);
        Done  = (state_q == DONE);
        State = state_q;
    end

    // Datapath: operand capture, one quotient bit per RUN edge (MSB first),
    // results loaded only on the final step so old results stay visible.
    always_ff @(posedge Clock or posedge Reset_b) begin
        if (Reset_b) begin
            cnt_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            acc_q <= '0;
            quo_q <= '0;
            rmd_q <= '0;
            dbz_q <= 1'b0;
        end else if (accept) begin
            if (Divisor == '0) begin
                quo_q <= '1;
                rmd_q <= Dividend[DIVISOR_W-1:0];
                dbz_q <= 1'b1;
            end else begin
                dvd_q <= Dividend;
                dvs_q <= Divisor;
                rem_q <= '0;
                acc_q <= '0;
                cnt_q <= CNT_W'(DIVIDEND_W - 1);
                dbz_q <= 1'b0;
            end
        end else if (state_q == RUN) begin
            rem_q <= step_rem;
            acc_q <= {acc_q[DIVIDEND_W-2:0], step_q};
            if (cnt_q == '0) begin
                quo_q <= {acc_q[DIVIDEND_W-2:0], step_q};
                rmd_q <= step_rem;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign Quotient  = quo_q;
    assign Remainder = rmd_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_alu_divider.sv
// Randomized self-checking bench for alu_divider against an arithmetic model.
module tb_alu_divider;
    import alu_div_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset_b;
    logic       Start;
    logic [7:0] Dividend;
    logic [3:0] Divisor;
    logic       Busy;
    logic       Done;
    logic [7:0] Quotient;
    logic [3:0] Remainder;
    logic       DivByZero;
    state_t     State;

    int n_checks = 0;
    int n_errors = 0;

    // Expected results {dbz, quotient, remainder}, one per accepted operation.
    logic [12:0] exp_q[$];
    logic [7:0]  prev_q;
    logic [3:0]  prev_r;

    alu_divider dut (
        .Clock     (Clock),
        .Reset_b   (Reset_b),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Busy      (Busy),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivByZero (DivByZero),
        .State     (State)
    );

    // Clock / reset
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [12:0] model(input logic [7:0] a, input logic [3:0] b);
        int q;
        int r;
        if (b == 0) return {1'b1, 8'hFF, a[3:0]};
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {1'b0, q[7:0], r[3:0]};
    endfunction

    // Driver: one operation, optionally pulsing a stray Start mid-RUN.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, input int inject_at);
        logic [12:0] e;
        int edges;
        exp_q.push_back(model(a, b));
        @(negedge Clock);
        Dividend = a;
        Divisor  = b;
        Start    = 1'b1;
        @(negedge Clock);
        Start    = 1'b0;
        Dividend = 8'($urandom);
        Divisor  = 4'($urandom);
        if (b == 0) begin
            check("dbz_busy", Busy, 0);
        end else begin
            check("e0_busy", Busy, 1);
            check("e0_done", Done, 0);
            check("e0_dbz", DivByZero, 0);
            check("held_q", Quotient, prev_q);
            check("held_r", Remainder, prev_r);
            edges = 0;
            while (!Done && edges < 20) begin
                @(negedge Clock);
                edges++;
                if (edges == inject_at) begin
                    Start    = 1'b1;
                    Dividend = 8'd50;
                    Divisor  = 4'd5;
                end else begin
                    Start = 1'b0;
                end
                if (!Done) check("run_busy", Busy, 1);
            end
            Start = 1'b0;
            check("latency", edges, 8);
        end
        e = exp_q.pop_front();
        check("done", Done, 1);
        check("busy_off", Busy, 0);
        check("quotient", Quotient, e[11:4]);
        check("remainder", Remainder, e[3:0]);
        check("divbyzero", DivByZero, e[12]);
        prev_q = e[11:4];
        prev_r = e[3:0];
    endtask

    initial begin
        logic [7:0] a;
        logic [3:0] b;
        Reset_b  = 1'b1;
        Start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        prev_q   = '0;
        prev_r   = '0;
        repeat (2) @(negedge Clock);
        check("rst_state", State, IDLE);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_q", Quotient, 0);
        check("rst_r", Remainder, 0);
        check("rst_dbz", DivByZero, 0);
        Reset_b = 1'b0;

        run_op(8'd200, 4'd7, 0);
        run_op(8'd255, 4'd1, 0);
        run_op(8'd13, 4'd15, 0);
        run_op(8'd100, 4'd0, 0);
        run_op(8'd9, 4'd2, 0);
        run_op(8'd200, 4'd7, 4);

        // Asynchronous reset in the middle of RUN, between clock edges.
        @(negedge Clock);
        Dividend = 8'd200;
        Divisor  = 4'd7;
        Start    = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (4) @(negedge Clock);
        @(posedge Clock);
        #2 Reset_b = 1'b1;
        #1;
        check("mid_rst_state", State, IDLE);
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_done", Done, 0);
        check("mid_rst_q", Quotient, 0);
        check("mid_rst_r", Remainder, 0);
        check("mid_rst_dbz", DivByZero, 0);
        #1 Reset_b = 1'b0;
        prev_q = '0;
        prev_r = '0;
        run_op(8'd50, 4'd5, 0);

        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            run_op(a, b, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
